// File: rtl/risc_pkg.sv
// Shared RISC definitions: boot-loader state encoding, instruction width,
// NOP word and the opcode constants used when assembling programs.
package risc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int I_SIZE = 16;
  localparam logic [I_SIZE-1:0] NOP_WORD = 16'h0000;  // ADD R0 R0 R0

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_ST   = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;

  function automatic logic [I_SIZE-1:0] asm_rrr(logic [3:0] op, logic [3:0] rd,
                                                logic [3:0] rs, logic [3:0] rt);
    return {op, rd, rs, rt};
  endfunction

  function automatic logic [I_SIZE-1:0] asm_ri(logic [3:0] op, logic [3:0] rd,
                                               logic [7:0] imm);
    return {op, rd, imm};
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Kept separate so a vendor RAM can be dropped in.
module imem_array #(
  parameter int DEPTH  = 1024,
  parameter int I_SIZE = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [I_SIZE-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [I_SIZE-1:0] rdata
);

  logic [I_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory with a streaming loader; holds the core in reset until
// the program image is loaded, then serves zero-latency fetches.
module imem_boot_loader #(
  parameter int                A_SIZE   = 10,
  parameter int                I_SIZE   = risc_pkg::I_SIZE,
  parameter int                DEPTH    = 1024,
  parameter logic [I_SIZE-1:0] NOP_WORD = risc_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [A_SIZE-1:0] pc,
  output logic [I_SIZE-1:0] instruction,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [I_SIZE-1:0] ld_data,
  input  logic              ld_last,
  input  logic              reload,
  output logic              core_rst,
  output logic              boot_done,
  output logic              load_err,
  output logic [A_SIZE:0]   wr_count
);
  import risc_pkg::*;

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [A_SIZE:0] DEPTH_W  = (A_SIZE+1)'(DEPTH);
  localparam logic [A_SIZE:0] LAST_IDX = (A_SIZE+1)'(DEPTH - 1);
  localparam logic [A_SIZE:0] ONE      = (A_SIZE+1)'(1);

  state_t            state;
  logic              we;
  logic              in_range;
  logic [I_SIZE-1:0] rdata;

  // reload wins over a simultaneous transfer: the word is never written
  assign we = ld_ready && ld_valid && !reload;

  imem_array #(
    .DEPTH  (DEPTH),
    .I_SIZE (I_SIZE),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (wr_count[AW-1:0]),
    .wdata (ld_data),
    .raddr (pc[AW-1:0]),
    .rdata (rdata)
  );

  // wr_count never exceeds DEPTH, so this also rejects pc >= DEPTH
  assign in_range    = {1'b0, pc} < wr_count;
  assign instruction = (state == RUN && in_range) ? rdata : NOP_WORD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_count  <= '0;
      ld_ready  <= 1'b0;
      core_rst  <= 1'b0;
      boot_done <= 1'b0;
      load_err  <= 1'b0;
    end else if (reload && state != IDLE) begin
      state     <= IDLE;
      ld_ready  <= 1'b0;
      core_rst  <= 1'b0;
      boot_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= LOAD;
          wr_count  <= '0;
          load_err  <= 1'b0;
          ld_ready  <= 1'b1;
          core_rst  <= 1'b0;
          boot_done <= 1'b0;
        end
        LOAD: begin
          if (ld_valid) begin
            if (wr_count != DEPTH_W) wr_count <= wr_count + ONE;
            if (ld_last) begin
              state    <= START;
              ld_ready <= 1'b0;
            end else if (wr_count == LAST_IDX) begin
              state    <= START;
              ld_ready <= 1'b0;
              load_err <= 1'b1;
            end
          end
        end
        START: state <= RUN;
        // core_rst lags entry into RUN by one edge: two reset cycles after the last write
        RUN: begin
          core_rst  <= 1'b1;
          boot_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: default instance plus a DEPTH=8
// instance for overflow behaviour.
module tb_imem_boot_loader;
  import risc_pkg::*;

  logic        clk;
  logic        rst, ld_valid, ld_last, reload;
  logic [9:0]  pc;
  logic [15:0] ld_data, instruction;
  logic        ld_ready, core_rst, boot_done, load_err;
  logic [10:0] wr_count;

  logic        rst8, ld_valid8, ld_last8, reload8;
  logic [9:0]  pc8;
  logic [15:0] ld_data8, instruction8;
  logic        ld_ready8, core_rst8, boot_done8, load_err8;
  logic [10:0] wr_count8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0]  pc;
    logic [15:0] exp;
    string       name;
  } rd_vec_t;

  rd_vec_t     rtab[16];
  logic [15:0] prog[14];

  imem_boot_loader dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .reload(reload), .core_rst(core_rst), .boot_done(boot_done),
    .load_err(load_err), .wr_count(wr_count)
  );

  imem_boot_loader #(.DEPTH(8)) dut8 (
    .clk(clk), .rst(rst8), .pc(pc8), .instruction(instruction8),
    .ld_valid(ld_valid8), .ld_ready(ld_ready8), .ld_data(ld_data8), .ld_last(ld_last8),
    .reload(reload8), .core_rst(core_rst8), .boot_done(boot_done8),
    .load_err(load_err8), .wr_count(wr_count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // holds ld_valid high until the word is accepted; returns 1ns after the transfer edge
  task automatic xfer(input logic [15:0] data, input logic last);
    logic ok;
    ok = 1'b0;
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ld_ready) begin
        step();
        ok = 1'b1;
        break;
      end
    end
    check("xfer_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_boot();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (boot_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("boot_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic rd(input string name, input logic [9:0] a, input logic [15:0] exp);
    pc = a;
    #1;
    check(name, {16'd0, instruction}, {16'd0, exp});
  endtask

  initial begin
    prog[0]  = asm_ri(OP_ADDI, 4'd8, 8'h07);    // 2807
    prog[1]  = asm_ri(OP_ADDI, 4'd9, 8'h06);    // 2906
    prog[2]  = asm_ri(OP_ADDI, 4'd10, 8'h05);   // 2A05
    prog[3]  = asm_ri(OP_ADDI, 4'd11, 8'h04);   // 2B04
    prog[4]  = asm_ri(OP_ADDI, 4'd12, 8'h03);   // 2C03
    prog[5]  = asm_ri(OP_ADDI, 4'd13, 8'h02);   // 2D02
    prog[6]  = asm_ri(OP_ADDI, 4'd14, 8'h01);   // 2E01
    prog[7]  = asm_rrr(OP_ADD, 4'd1, 4'd2, 4'd3); // 0123
    prog[8]  = asm_rrr(OP_ADD, 4'd2, 4'd0, 4'd11); // 020B
    prog[9]  = asm_rrr(OP_ADD, 4'd3, 4'd4, 4'd5); // 0345
    prog[10] = asm_rrr(OP_SUB, 4'd4, 4'd5, 4'd6); // 1456
    prog[11] = asm_rrr(OP_LD, 4'd5, 4'd6, 4'd7);  // 3567
    prog[12] = asm_rrr(OP_ST, 4'd6, 4'd7, 4'd8);  // 4678
    prog[13] = asm_ri(OP_ADDI, 4'd0, 8'h00);      // 2000
    rtab[0]  = '{10'd0,  16'h2807, "rd_pc0"};
    rtab[1]  = '{10'd1,  16'h2906, "rd_pc1"};
    rtab[2]  = '{10'd2,  16'h2A05, "rd_pc2"};
    rtab[3]  = '{10'd3,  16'h2B04, "rd_pc3"};
    rtab[4]  = '{10'd4,  16'h2C03, "rd_pc4"};
    rtab[5]  = '{10'd5,  16'h2D02, "rd_pc5"};
    rtab[6]  = '{10'd6,  16'h2E01, "rd_pc6"};
    rtab[7]  = '{10'd7,  16'h0123, "rd_pc7"};
    rtab[8]  = '{10'd8,  16'h020B, "rd_pc8"};
    rtab[9]  = '{10'd9,  16'h0345, "rd_pc9"};
    rtab[10] = '{10'd10, 16'h1456, "rd_pc10"};
    rtab[11] = '{10'd11, 16'h3567, "rd_pc11"};
    rtab[12] = '{10'd12, 16'h4678, "rd_pc12"};
    rtab[13] = '{10'd13, 16'h2000, "rd_pc13"};
    rtab[14] = '{10'd14, 16'h0000, "rd_oor14"};
    rtab[15] = '{10'd1023, 16'h0000, "rd_oor1023"};

    rst = 1'b1; rst8 = 1'b1;
    ld_valid = 0; ld_last = 0; ld_data = '0; reload = 0; pc = '0;
    ld_valid8 = 0; ld_last8 = 0; ld_data8 = '0; reload8 = 0; pc8 = '0;
    #2;
    rst = 1'b0; rst8 = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_wr_count", {21'd0, wr_count}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_core_rst", {31'd0, core_rst}, 32'd0);
    check("rst_boot_done", {31'd0, boot_done}, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    check("rst_instr", {16'd0, instruction}, 32'd0);
    step();
    rst = 1'b1; rst8 = 1'b1;

    // scenario 1: basic boot, streaming
    xfer(prog[0], 1'b0);
    rd("load_pc0_nop", 10'd0, 16'h0000);
    for (int i = 1; i < 14; i++) xfer(prog[i], (i == 13));
    ld_valid = 0; ld_last = 0;
    check("s1_core_rst_e0", {31'd0, core_rst}, 32'd0);
    check("s1_wr_count", {21'd0, wr_count}, 32'd14);
    step();
    check("s1_core_rst_e1", {31'd0, core_rst}, 32'd0);
    step();
    check("s1_core_rst_e2", {31'd0, core_rst}, 32'd1);
    check("s1_boot_done", {31'd0, boot_done}, 32'd1);
    check("s1_load_err", {31'd0, load_err}, 32'd0);

    // scenarios 1/2: read table incl. out-of-range
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd(rtab[i].name, rtab[i].pc, rtab[i].exp);
    end

    // scenario 5: reload with a 2-word image
    step();
    reload = 1'b1;
    step();
    reload = 1'b0;
    check("s5_core_rst", {31'd0, core_rst}, 32'd0);
    check("s5_boot_done", {31'd0, boot_done}, 32'd0);
    check("s5_ld_ready_idle", {31'd0, ld_ready}, 32'd0);
    step();
    check("s5_wr_count0", {21'd0, wr_count}, 32'd0);
    check("s5_ld_ready", {31'd0, ld_ready}, 32'd1);
    xfer(16'h2C01, 1'b0);
    xfer(16'h2000, 1'b1);
    ld_valid = 0; ld_last = 0;
    wait_boot();
    check("s5_wr_count", {21'd0, wr_count}, 32'd2);
    check("s5_load_err", {31'd0, load_err}, 32'd0);
    rd("s5_pc0", 10'd0, 16'h2C01);
    rd("s5_pc1", 10'd1, 16'h2000);
    rd("s5_pc2_nop", 10'd2, 16'h0000);

    // scenario 3: ld_valid toggling every other cycle
    step();
    reload = 1'b1;
    step();
    reload = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b0;
      step();
      check("s3_stall_count", {21'd0, wr_count}, i);
      ld_valid = 1'b1;
      ld_data  = 16'h1111 * 16'(i + 1);
      ld_last  = (i == 3);
      step();
      check("s3_xfer_count", {21'd0, wr_count}, i + 1);
    end
    ld_valid = 0; ld_last = 0;
    wait_boot();
    check("s3_wr_count", {21'd0, wr_count}, 32'd4);
    for (int i = 0; i < 4; i++) rd("s3_data", 10'(i), 16'h1111 * 16'(i + 1));
    rd("s3_pc4_nop", 10'd4, 16'h0000);

    // scenario 6: async reset mid-load
    step();
    reload = 1'b1;
    step();
    reload = 1'b0;
    for (int i = 0; i < 5; i++) xfer(16'h5000 + 16'(i), 1'b0);
    ld_valid = 0;
    check("s6_count5", {21'd0, wr_count}, 32'd5);
    #2;
    rst = 1'b0;
    #1;
    check("s6_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("s6_core_rst", {31'd0, core_rst}, 32'd0);
    check("s6_boot_done", {31'd0, boot_done}, 32'd0);
    check("s6_wr_count", {21'd0, wr_count}, 32'd0);
    step();
    rst = 1'b1;
    #1;
    check("s6_idle_ready", {31'd0, ld_ready}, 32'd0);
    step();
    check("s6_reload_ready", {31'd0, ld_ready}, 32'd1);
    check("s6_reload_count", {21'd0, wr_count}, 32'd0);

    // scenario 4: overflow on the DEPTH=8 instance
    for (int i = 0; i < 10; i++) begin
      ld_valid8 = 1'b1;
      ld_data8  = 16'h3000 + 16'(i);
      step();
      if (i == 7) begin
        check("s4_ready_drop", {31'd0, ld_ready8}, 32'd0);
        check("s4_load_err", {31'd0, load_err8}, 32'd1);
        check("s4_wr_count8", {21'd0, wr_count8}, 32'd8);
      end
    end
    ld_valid8 = 1'b0;
    check("s4_wr_count_final", {21'd0, wr_count8}, 32'd8);
    check("s4_core_rst", {31'd0, core_rst8}, 32'd1);
    check("s4_boot_done", {31'd0, boot_done8}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      pc8 = 10'(i);
      #1;
      check("s4_rd", {16'd0, instruction8}, (i < 8) ? 32'h3000 + i : 32'd0);
    end
    step();
    reload8 = 1'b1;
    step();
    reload8 = 1'b0;
    check("s4_reload_core_rst", {31'd0, core_rst8}, 32'd0);
    step();
    check("s4_reload_err_clr", {31'd0, load_err8}, 32'd0);
    check("s4_reload_count", {21'd0, wr_count8}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Instruction-memory responder for the RISC core: serves `instruction` for the core-driven `pc` with zero latency.
- Owns a streaming loader port that fills the memory after reset or on demand.
- Holds the core in reset (`core_rst` low) until the program image has been loaded.
- Sits between the program source (bench, UART bridge) and the core's `pc`/`instruction` interface.

Parameters:
- A_SIZE, 10, width of `pc` and of the word address.
- I_SIZE, 16, instruction width.
- DEPTH, 1024, number of instruction words; must be ≤ 2**A_SIZE.
- NOP_WORD, 16'h0000, word returned for unloaded or out-of-range addresses (ADD R0 R0 R0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc  in  A_SIZE  fetch address from core.
- instruction  out  I_SIZE  fetched word to core.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  loader can accept a word.
- ld_data  in  I_SIZE  loader word.
- ld_last  in  1  qualifies the final word of the image.
- reload  in  1  synchronous request to reload the image.
- core_rst  out  1  active-low reset to core; registered.
- boot_done  out  1  image loaded, core running.
- load_err  out  1  image exceeded DEPTH without ld_last; sticky until rst or reload.
- wr_count  out  A_SIZE+1  number of words loaded.

Behaviour:
- Reset values (rst low): state=IDLE, wr_count=0, ld_ready=0, core_rst=0, boot_done=0, load_err=0. Memory array is not reset.
- States: IDLE, LOAD, START, RUN.
- IDLE:
  - Always moves to LOAD on the next edge.
  - Clears wr_count and load_err.
  - core_rst=0.
- LOAD:
  - ld_ready=1.
  - A transfer happens only when ld_valid && ld_ready.
  - On a transfer: mem[wr_count]<=ld_data; wr_count<=wr_count+1.
  - Transfer with ld_last=1 -> START.
  - Transfer at wr_count==DEPTH-1 with ld_last=0 -> START, and load_err<=1.
  - ld_valid low stalls with no state change; no timeout.
- START:
  - ld_ready=0, core_rst=0.
  - Exactly one cycle, then RUN. This gives the core at least one reset cycle after the last write.
- RUN:
  - core_rst=1, boot_done=1, ld_ready=0.
  - ld_valid is ignored.
- reload=1 in any state except IDLE -> IDLE on the next edge.
  - core_rst drops to 0 and boot_done to 0 on that same edge.
  - reload has priority over a simultaneous loader transfer; that word is discarded.
- Empty image: a single word with ld_last is the minimum. An image of zero words is not possible.
- Read path (combinational, zero latency):
  - instruction = mem[pc] when state==RUN and pc < wr_count.
  - Otherwise instruction = NOP_WORD.
  - A pc at or beyond wr_count or DEPTH never reads stale memory.
- wr_count saturates at DEPTH; it never wraps.
- rst asserted mid-load aborts immediately: all outputs return to reset values and memory contents are don't-care.

Decomposition:
- Shared package `risc_pkg`:
  - state encoding (IDLE=2'd0, LOAD=2'd1, START=2'd2, RUN=2'd3);
  - I_SIZE and NOP_WORD constants;
  - the opcode constants already used by the core (bench program assembly).
- One sub-module: `imem_array`.
  - Single write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
  - Parameterised by DEPTH/I_SIZE.
  - Keeps the array replaceable by a vendor RAM.
- FSM, counter and read-path muxing stay in `imem_boot_loader`.

Test Plan:
1. Basic boot.
   - Stimulus: rst low 2 cycles, release; stream 14 words with ld_valid held high, ld_last on word 13: 16'h2807, 16'h2906, …, 16'h2000.
   - Required: wr_count=14; core_rst rises exactly 2 cycles after the last transfer edge; boot_done=1; pc=0 -> 16'h2807 and pc=8 -> 16'h020B in the same cycle.
2. Out-of-range reads.
   - Stimulus: after scenario 1, drive pc=14 and pc=1023.
   - Required: instruction=16'h0000. Also, during LOAD, pc=0 returns 16'h0000 even after word 0 is written.
3. Backpressure/stall.
   - Stimulus: toggle ld_valid every other cycle across 4 words, ld_last on the 4th.
   - Required: exactly 4 writes, wr_count=4; data at pc 0..3 matches in order; no duplicates.
4. Overflow.
   - Stimulus: DEPTH=8 instance; stream 10 words, never asserting ld_last.
   - Required: the first 8 are accepted; ld_ready drops after the 8th; load_err=1; wr_count=8; core_rst released; words 9–10 are ignored.
5. Reload.
   - Stimulus: in RUN, pulse reload one cycle; load 2 words 16'h2C01, 16'h2000 with ld_last on the 2nd.
   - Required: core_rst=0 and boot_done=0 on the next edge; wr_count restarts at 0 and ends at 2; pc=2 returns NOP; load_err cleared.
6. Reset mid-load.
   - Stimulus: assert rst asynchronously between clock edges after 5 words.
   - Required: ld_ready, core_rst, boot_done and wr_count go to 0 immediately without waiting for a clock edge; after release the FSM re-enters LOAD one edge later.
